// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin memory arbiter for PROC_COUNT processors
//
// Purpose: grants one processor at a time access to a single memory port.
// Writes take a GRANT cycle and return to IDLE; reads go through RD_WAIT
// until the memory returns data, then pulse o_valid for the winner.
//
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, a read that sees
// no i_mem_rvalid for 255 RD_WAIT cycles completes with o_data=0 and o_err=1.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_rd, i_req_wr           per-processor read / write requests
//   i_addr, i_data, i_wr_size    per-processor address, write data, size
//   o_grant_rd, o_grant_wr       one-hot grants (single-cycle)
//   o_valid, o_data              one-hot read valid, broadcast read data
//   o_mem_en/we/addr/wdata/size  memory command
//   i_mem_rdata, i_mem_rvalid    memory read return
//   o_busy, o_err                not-idle indicator, read timeout error

package mem_arbiter_pkg;
    typedef logic [15:0] addr_t;
endpackage

`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif
`ifndef BUS_W
`define BUS_W 32
`endif

module mem_arbiter #(
    parameter int PROC_COUNT = `PROC_COUNT,
    parameter int BUS_W      = `BUS_W,
    parameter int ADDR_W     = $bits(mem_arbiter_pkg::addr_t)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [PROC_COUNT-1:0]             i_req_rd,
    input  logic [PROC_COUNT-1:0]             i_req_wr,
    input  logic [PROC_COUNT-1:0][ADDR_W-1:0] i_addr,
    input  logic [PROC_COUNT-1:0][BUS_W-1:0]  i_data,
    input  logic [PROC_COUNT-1:0][2:0]        i_wr_size,
    output logic [PROC_COUNT-1:0]             o_grant_rd,
    output logic [PROC_COUNT-1:0]             o_grant_wr,
    output logic [PROC_COUNT-1:0]             o_valid,
    output logic [BUS_W-1:0]                  o_data,
    output logic                              o_mem_en,
    output logic                              o_mem_we,
    output logic [ADDR_W-1:0]                 o_mem_addr,
    output logic [BUS_W-1:0]                  o_mem_wdata,
    output logic [2:0]                        o_mem_size,
    input  logic [BUS_W-1:0]                  i_mem_rdata,
    input  logic                              i_mem_rvalid,
    output logic                              o_busy,
    output logic                              o_err
);

    localparam int IDX_W = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   idx;
    logic               is_wr;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W-1:0]   rr_ptr_nx;
    logic [PROC_COUNT-1:0] req_any;
    logic [BUS_W-1:0]   data_q;
    logic               timeout;
    int                 cand;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]         to_cnt;
    logic               err_q;
`endif

    assign req_any = i_req_rd | i_req_wr;

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int i = 0; i < PROC_COUNT; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= PROC_COUNT) begin
                cand = cand - PROC_COUNT;
            end
            if (!win_found && req_any[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        if (win_idx == IDX_W'(PROC_COUNT - 1)) begin
            rr_ptr_nx = '0;
        end else begin
            rr_ptr_nx = win_idx + 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Counter value 254 marks the 255th RD_WAIT cycle.
    assign timeout = (to_cnt == 8'd254) && !i_mem_rvalid;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            idx    <= '0;
            is_wr  <= 1'b0;
            data_q <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt <= 8'd0;
            err_q  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && win_found) begin
                idx    <= win_idx;
                // A processor asserting both requests is served as a write;
                // its read stays pending for a later arbitration.
                is_wr  <= i_req_wr[win_idx];
                rr_ptr <= rr_ptr_nx;
            end
            if (state == RD_WAIT) begin
                if (i_mem_rvalid) begin
                    data_q <= i_mem_rdata;
                end else if (timeout) begin
                    data_q <= '0;
                end
            end
`ifdef ARB_TIMEOUT_EN
            if (state == GRANT) begin
                to_cnt <= 8'd0;
                err_q  <= 1'b0;
            end else if (state == RD_WAIT) begin
                to_cnt <= to_cnt + 8'd1;
                if (timeout) begin
                    err_q <= 1'b1;
                end
            end
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_found) state_nx = GRANT;
            GRANT:   state_nx = is_wr ? IDLE : RD_WAIT;
            RD_WAIT: if (i_mem_rvalid || timeout) state_nx = RD_RESP;
            RD_RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_grant_rd  = '0;
        o_grant_wr  = '0;
        o_valid     = '0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_size  = '0;
        if (state == GRANT) begin
            o_mem_en    = 1'b1;
            o_mem_we    = is_wr;
            o_mem_addr  = i_addr[idx];
            o_mem_wdata = i_data[idx];
            o_mem_size  = i_wr_size[idx];
            if (is_wr) begin
                o_grant_wr[idx] = 1'b1;
            end else begin
                o_grant_rd[idx] = 1'b1;
            end
        end
        if (state == RD_RESP) begin
            o_valid[idx] = 1'b1;
        end
    end

    assign o_data = data_q;
    assign o_busy = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    assign o_err = (state == RD_RESP) && err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req_rd;
    logic [3:0]       req_wr;
    logic [3:0][15:0] addr;
    logic [3:0][31:0] wdata;
    logic [3:0][2:0]  wr_size;
    logic [3:0]       grant_rd;
    logic [3:0]       grant_wr;
    logic [3:0]       valid;
    logic [31:0]      rd_data;
    logic             mem_en;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [2:0]       mem_size;
    logic [31:0]      mem_rdata;
    logic             mem_rvalid;
    logic             busy;
    logic             err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(
        .PROC_COUNT(4),
        .BUS_W(32),
        .ADDR_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req_rd(req_rd),
        .i_req_wr(req_wr),
        .i_addr(addr),
        .i_data(wdata),
        .i_wr_size(wr_size),
        .o_grant_rd(grant_rd),
        .o_grant_wr(grant_wr),
        .o_valid(valid),
        .o_data(rd_data),
        .o_mem_en(mem_en),
        .o_mem_we(mem_we),
        .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_size(mem_size),
        .i_mem_rdata(mem_rdata),
        .i_mem_rvalid(mem_rvalid),
        .o_busy(busy),
        .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] oh_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Complete one read from processor p with no checking.
    task automatic do_read(input int p, input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        req_rd  = 4'b0001 << p;
        addr[p] = a;
        @(negedge clk);
        req_rd = 4'b0000;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst    = 1'b1;
        req_wr = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || grant_rd !== 4'b0 || grant_wr !== 4'b0 || valid !== 4'b0 ||
            mem_en !== 1'b0 || mem_we !== 1'b0 || rd_data !== 32'h0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b grd=%b gwr=%b val=%b en=%b we=%b data=%h err=%b want all 0",
                     busy, grant_rd, grant_wr, valid, mem_en, mem_we, rd_data, err);
        end
        req_wr = 4'b0000;
        rst    = 1'b0;
    endtask

    task automatic test_single_read();
        pulse_reset();
        @(negedge clk);
        req_rd  = 4'b0010;
        addr[1] = 16'h0010;
        @(negedge clk);
        total++;
        if (grant_rd !== 4'b0010 || grant_wr !== 4'b0000 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
            mem_addr !== 16'h0010 || busy !== 1'b1) begin
            bad++;
            $display("FAIL read_grant: grd=%b gwr=%b en=%b we=%b addr=%h busy=%b want 0010 0000 1 0 0010 1",
                     grant_rd, grant_wr, mem_en, mem_we, mem_addr, busy);
        end
        req_rd = 4'b0000;
        @(negedge clk);
        total++;
        if (valid !== 4'b0000 || mem_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL read_wait: val=%b en=%b busy=%b want 0000 0 1", valid, mem_en, busy);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00AB;
        @(negedge clk);
        total++;
        if (valid !== 4'b0010 || rd_data !== 32'h0000_00AB) begin
            bad++;
            $display("FAIL read_resp: val=%b data=%h want 0010 000000ab", valid, rd_data);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(negedge clk);
        total++;
        if (valid !== 4'b0000 || busy !== 1'b0 || rd_data !== 32'h0000_00AB) begin
            bad++;
            $display("FAIL read_after: val=%b busy=%b data=%h want 0000 0 000000ab", valid, busy, rd_data);
        end
    endtask

    task automatic test_rr_writes();
        int p;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            addr[i]    = 16'h0100 + 16'(i);
            wdata[i]   = 32'hD000_0000 + 32'(i);
            wr_size[i] = 3'(i + 1);
        end
        @(negedge clk);
        req_wr = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            p = k % 4;
            @(negedge clk);
            total++;
            if (grant_wr !== (4'b0001 << p) || grant_rd !== 4'b0000 || mem_en !== 1'b1 ||
                mem_we !== 1'b1 || mem_addr !== (16'h0100 + 16'(p)) ||
                mem_wdata !== (32'hD000_0000 + 32'(p)) || mem_size !== 3'(p + 1)) begin
                bad++;
                $display("FAIL rr_write_%0d: gwr=%b we=%b addr=%h data=%h size=%0d want proc %0d",
                         k, grant_wr, mem_we, mem_addr, mem_wdata, mem_size, p);
            end
            @(negedge clk);
            total++;
            if (grant_wr !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rr_gap_%0d: gwr=%b busy=%b want 0000 0", k, grant_wr, busy);
            end
        end
        req_wr = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_rd_wr_same();
        logic [2:0] ev [4];
        logic [2:0] exp_ev [4];
        int         n;
        bit         rv_next;
        logic [3:0] vseen;
        logic [31:0] vdata;
        exp_ev[0] = 3'b100;
        exp_ev[1] = 3'b110;
        exp_ev[2] = 3'b111;
        exp_ev[3] = 3'b010;
        for (int i = 0; i < 4; i++) ev[i] = 3'b000;
        n = 0;
        rv_next = 1'b0;
        vseen = 4'b0;
        vdata = 32'h0;
        pulse_reset();
        @(negedge clk);
        req_wr    = 4'b1101;
        req_rd    = 4'b0100;
        mem_rdata = 32'h2222_0002;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            mem_rvalid = rv_next;
            rv_next    = 1'b0;
            if (grant_wr !== 4'b0000) begin
                if (n < 4) ev[n] = {1'b1, oh_idx(grant_wr)};
                n++;
                req_wr = req_wr & ~grant_wr;
            end
            if (grant_rd !== 4'b0000) begin
                if (n < 4) ev[n] = {1'b0, oh_idx(grant_rd)};
                n++;
                req_rd  = req_rd & ~grant_rd;
                rv_next = 1'b1;
            end
            if (valid !== 4'b0000) begin
                vseen = valid;
                vdata = rd_data;
            end
            if (n >= 4 && vseen !== 4'b0000) break;
        end
        mem_rvalid = 1'b0;
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL both_count: grants=%0d want 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ev[i] !== exp_ev[i]) begin
                bad++;
                $display("FAIL both_order_%0d: got {wr,idx}=%b want %b", i, ev[i], exp_ev[i]);
            end
        end
        total++;
        if (vseen !== 4'b0100 || vdata !== 32'h2222_0002) begin
            bad++;
            $display("FAIL both_read_resp: val=%b data=%h want 0100 22220002", vseen, vdata);
        end
        req_wr = 4'b0000;
        req_rd = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_in_rd_wait();
        pulse_reset();
        @(negedge clk);
        req_rd  = 4'b0010;
        addr[1] = 16'h0044;
        @(negedge clk);
        req_rd = 4'b0000;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait_entry: busy=%b en=%b want 1 0", busy, mem_en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0077;
        total++;
        if (busy !== 1'b0 || valid !== 4'b0000) begin
            bad++;
            $display("FAIL rst_wait_idle: busy=%b val=%b want 0 0000", busy, valid);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 4'b0000 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_wait_ignore: busy=%b val=%b data=%h want 0 0000 0", busy, valid, rd_data);
        end
        req_wr = 4'b1111;
        @(negedge clk);
        total++;
        if (grant_wr !== 4'b0001) begin
            bad++;
            $display("FAIL rst_wait_rrptr: gwr=%b want 0001", grant_wr);
        end
        req_wr = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_idle_rvalid();
        pulse_reset();
        do_read(3, 16'h0033, 32'h0000_005A);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (rd_data !== 32'h0000_005A || valid !== 4'b0000 || busy !== 1'b0 || mem_en !== 1'b0 ||
            grant_rd !== 4'b0000 || grant_wr !== 4'b0000 || err !== 1'b0) begin
            bad++;
            $display("FAIL idle_rvalid: data=%h val=%b busy=%b en=%b grd=%b gwr=%b err=%b want data 0000005a rest 0",
                     rd_data, valid, busy, mem_en, grant_rd, grant_wr, err);
        end
    endtask

    task automatic test_short_req();
        @(negedge clk);
        req_rd = 4'b0001;
        #2;
        req_rd = 4'b0000;
        @(negedge clk);
        total++;
        if (grant_rd !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL short_req: grd=%b busy=%b want 0000 0", grant_rd, busy);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit early;
        early = 1'b0;
        pulse_reset();
        do_read(1, 16'h0020, 32'h0000_0055);
        @(negedge clk);
        req_rd  = 4'b0100;
        addr[2] = 16'h0022;
        @(negedge clk);
        req_rd = 4'b0000;
        total++;
        if (grant_rd !== 4'b0100) begin
            bad++;
            $display("FAIL to_grant: grd=%b want 0100", grant_rd);
        end
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            if (valid !== 4'b0000 || busy !== 1'b1 || err !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin
            bad++;
            $display("FAIL to_wait: early response or idle during 255 wait cycles, got 1 want 0");
        end
        @(negedge clk);
        total++;
        if (valid !== 4'b0100 || rd_data !== 32'h0 || err !== 1'b1) begin
            bad++;
            $display("FAIL to_resp: val=%b data=%h err=%b want 0100 0 1", valid, rd_data, err);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0 || valid !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL to_after: err=%b val=%b busy=%b want 0 0000 0", err, valid, busy);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        req_rd     = 4'b0000;
        req_wr     = 4'b0000;
        addr       = '0;
        wdata      = '0;
        wr_size    = '0;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        test_reset();
        test_single_read();
        test_rr_writes();
        test_rd_wr_same();
        test_reset_in_rd_wait();
        test_idle_rvalid();
        test_short_req();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter PROC_COUNT, default `PROC_COUNT, the number of requesting processors.
REQ-002 SHALL have parameter BUS_W, default `BUS_W, the data bus width.
REQ-003 SHALL have parameter ADDR_W, default $bits(addr_t), the address width.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, a synchronous active-high reset.
REQ-006 SHALL have ports i_req_rd and i_req_wr, input, PROC_COUNT each, per-processor read and write requests.
REQ-007 SHALL have port i_addr, input, PROC_COUNT x ADDR_W, per-processor address.
REQ-008 SHALL have port i_data, input, PROC_COUNT x BUS_W, per-processor write data.
REQ-009 SHALL have port i_wr_size, input, PROC_COUNT x 3, per-processor write size.
REQ-010 SHALL have ports o_grant_rd and o_grant_wr, output, PROC_COUNT each, one-hot grants.
REQ-011 SHALL have port o_valid, output, PROC_COUNT, one-hot read-data-valid.
REQ-012 SHALL have port o_data, output, BUS_W, read data broadcast to all processors.
REQ-013 SHALL have ports o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata and o_mem_size, output, widths 1/1/ADDR_W/BUS_W/3, the memory command.
REQ-014 SHALL have ports i_mem_rdata (input, BUS_W) and i_mem_rvalid (input, 1), the memory read return.
REQ-015 SHALL have outputs o_busy (1) and o_err (1).

Function
REQ-016 SHALL implement the states IDLE, GRANT, RD_WAIT and RD_RESP.
REQ-017 In IDLE with any request bit set, SHALL select the winner round-robin over (i_req_rd | i_req_wr), searching upward from rr_ptr and wrapping, register the winner's index and type, and go to GRANT.
REQ-018 If the winner asserts both requests, SHALL serve the write first; the read is served in a later arbitration.
REQ-019 SHALL, on grant, set rr_ptr to winner+1 modulo PROC_COUNT.
REQ-020 In GRANT, SHALL hold o_grant_rd[idx] or o_grant_wr[idx] high for exactly 1 cycle and o_mem_en=1.
REQ-021 In GRANT, o_mem_addr, o_mem_wdata and o_mem_size SHALL be muxed from the registered idx.
REQ-022 For a write, GRANT SHALL set o_mem_we=1 and go to IDLE next cycle; back-to-back grants occur every 2 cycles.
REQ-023 For a read, GRANT SHALL set o_mem_we=0 and go to RD_WAIT.
REQ-024 In RD_WAIT, SHALL on i_mem_rvalid register i_mem_rdata into o_data and go to RD_RESP.
REQ-025 In RD_RESP, SHALL hold o_valid[idx]=1 for 1 cycle, then go to IDLE.
REQ-026 o_data SHALL hold its last value until the next read response.
REQ-027 Minimum read latency SHALL be: request at cycle N, grant at N+1, rvalid at N+2, o_valid at N+3.
REQ-028 i_mem_rvalid outside RD_WAIT SHALL be ignored.
REQ-029 A request deasserted before being sampled in IDLE SHALL not be granted.
REQ-030 Requests are never queued; only the IDLE-cycle vector matters.
REQ-031 At most one bit of o_grant_rd | o_grant_wr | o_valid SHALL ever be set.
REQ-032 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-033 On i_rst=1 at a clock edge, SHALL go to IDLE with rr_ptr=0, all grants and valids 0, o_mem_en=0, o_mem_we=0, o_data=0, o_err=0 and o_busy=0.
REQ-034 Reset in any state SHALL abandon the in-flight transfer; a later i_mem_rvalid is ignored.

Configuration
REQ-035 With ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to RD_WAIT and increment each RD_WAIT cycle.
REQ-036 With ARB_TIMEOUT_EN defined, if 255 cycles pass without i_mem_rvalid, SHALL load o_data=0, pulse o_err=1 for the RD_RESP cycle, and complete normally.
REQ-037 Without ARB_TIMEOUT_EN, RD_WAIT SHALL wait indefinitely and o_err SHALL be tied 0.

Verification
REQ-038 Reset, then i_req_rd=4'b0010, addr 0x10, rdata 0xAB with rvalid 1 cycle after grant -> o_grant_rd=0010 at N+1, o_valid=0010 and o_data=0xAB at N+3.
REQ-039 i_req_wr=4'b1111 held -> grants in order 0,1,2,3,0 every 2 cycles, each with o_mem_we=1 and the matching addr/data/size.
REQ-040 Proc 2 asserts both rd and wr -> write granted first; the read is granted after the other requesters are served.
REQ-041 i_rst pulsed during RD_WAIT, then i_mem_rvalid -> no o_valid; state IDLE; rr_ptr=0.
REQ-042 ARB_TIMEOUT_EN defined, no rvalid -> after 255 RD_WAIT cycles o_valid[idx]=1, o_data=0, o_err=1 for 1 cycle.
REQ-043 i_mem_rvalid pulsed while IDLE with no requests -> all outputs unchanged.
